flash_stream_reader: RTL and testbench
======================================

Name: flash_stream_reader

Overview:
- Sits between the qspi_flash controller and the SPI debug command handler.
- Takes a (start address, byte count) request and issues sequential single-byte reads over the flash do_read/data_ready handshake.
- Buffers the returned bytes in a small synchronous FIFO that the SPI reply logic pops one byte per transfer.
- Enables multi-byte flash dumps instead of one byte per command.

Parameters:
FIFO_AW, 4, log2 of FIFO depth (depth = 16 bytes)
LEN_W, 16, width of byte-count request

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request strobe
start_addr  in  24  first flash byte address
length  in  LEN_W  number of bytes to read
abort  in  1  one-cycle cancel strobe
busy  out  1  request in progress
done  out  1  one-cycle pulse when request completes or abort finishes
flash_setup_done  in  1  flash controller ready
flash_addr  out  24  address presented to flash controller
flash_do_read  out  1  read request level to flash controller
flash_data_ready  in  1  one-cycle pulse, flash_data valid
flash_data  in  8  byte from flash
pop  in  1  consumer removes head byte
rd_data  out  8  FIFO head byte, valid when rd_valid
rd_valid  out  1  FIFO not empty
level  out  FIFO_AW+1  current FIFO occupancy
checksum  out  8  running byte sum (see Optional Feature)

Behaviour:
- Reset values:
  - busy=0, done=0, flash_do_read=0, flash_addr=0, level=0, rd_valid=0, rd_data=0, checksum=0.
  - State IDLE; FIFO pointers 0.
- States: IDLE, ISSUE, WAIT_DATA, GAP, ABORTING.
- IDLE:
  - start=1 and abort=0 latches cur_addr=start_addr, remaining=length, clears checksum, flushes FIFO.
  - If length==0: done pulses next cycle, busy stays 0.
  - Otherwise busy=1 and next state is ISSUE.
  - start while busy is ignored.
- ISSUE:
  - Waits for flash_setup_done=1 and free FIFO space (level < 2^FIFO_AW).
  - Then drives flash_addr=cur_addr, flash_do_read=1, and moves to WAIT_DATA.
- WAIT_DATA:
  - flash_do_read held 1 until flash_data_ready.
  - On flash_data_ready: push flash_data into FIFO, flash_do_read<=0, cur_addr+1 (wraps 0xFFFFFF->0x000000), remaining-1.
  - Next state is GAP.
- GAP:
  - One cycle with flash_do_read=0, guaranteeing a deasserted gap between requests.
  - If remaining==0: done pulse, busy<=0, return to IDLE. Otherwise go to ISSUE.
- At most one read outstanding; space is checked before issue, so a push can never overflow.
- abort=1 while busy:
  - From ISSUE or GAP: go to IDLE immediately.
  - From WAIT_DATA: go to ABORTING, wait for flash_data_ready, discard the byte, drop do_read, go to IDLE.
  - In all cases the FIFO is flushed, done pulses once on the transition to IDLE, and busy clears with it.
  - abort in IDLE is ignored.
- Simultaneous start and abort in IDLE: abort wins, nothing starts.
- FIFO:
  - rd_data is combinational from the head entry.
  - pop with rd_valid=0 is ignored.
  - push and pop in the same cycle leave level unchanged.
  - Bytes remaining after done stay poppable until the next start, which flushes them.
- Latency: first byte is visible at rd_valid two cycles after flash_data_ready is sampled (push register, then level update), not later.
- flash_setup_done low in WAIT_DATA has no effect; the outstanding read still completes.
- Reset mid-operation returns everything to reset values immediately.

Optional Feature:
- Macro FLASH_STREAM_CHECKSUM_EN.
- When defined: checksum is an 8-bit modulo-256 sum of every byte pushed into the FIFO. It is cleared on an accepted start; bytes discarded by abort are excluded.
- When undefined: checksum is constant 0 and no accumulator logic is built.

Test Plan:
- start_addr=0x000100, length=4; flash model returns addr[7:0] after 3 cycles.
  - rd_data pops 0x00,0x01,0x02,0x03 in order; done pulses once.
  - checksum=0x06 with the macro, 0 without.
- length=0 -> done pulses one cycle after start; flash_do_read never asserts; busy stays 0.
- start_addr=0xFFFFFE, length=3 -> flash_addr sequence 0xFFFFFE, 0xFFFFFF, 0x000000.
- length=20 with no pops:
  - Exactly 16 reads are issued, then level=16 and flash_do_read stays 0.
  - Pop 4 bytes -> 4 more reads issue, then done.
- abort asserted during WAIT_DATA -> do_read stays high until data_ready, then drops; level=0; done pulses once; the next start is accepted normally.
- flash_setup_done held 0 for 50 cycles after start -> no do_read until it rises; then normal completion.

Source files
------------

// File: rtl/flash_stream_reader_if.sv
// Single-byte read handshake between flash_stream_reader (master) and the qspi_flash controller (slave).
interface flash_stream_reader_if;
    logic        flash_setup_done;
    logic [23:0] flash_addr;
    logic        flash_do_read;
    logic        flash_data_ready;
    logic [7:0]  flash_data;

    modport master (
        input  flash_setup_done,
        input  flash_data_ready,
        input  flash_data,
        output flash_addr,
        output flash_do_read
    );

    modport slave (
        output flash_setup_done,
        output flash_data_ready,
        output flash_data,
        input  flash_addr,
        input  flash_do_read
    );
endinterface

// File: rtl/flash_stream_reader.sv
// Turns a (start address, byte count) request into sequential single-byte flash reads buffered in a FIFO.
// Define FLASH_STREAM_CHECKSUM_EN to build the modulo-256 checksum of pushed bytes; otherwise checksum is 0.
module flash_stream_reader #(
    parameter int FIFO_AW = 4,
    parameter int LEN_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [23:0]           start_addr,
    input  logic [LEN_W-1:0]      length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    flash_stream_reader_if.master flash,
    input  logic                  pop,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic [FIFO_AW:0]      level,
    output logic [7:0]            checksum
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DATA,
        GAP,
        ABORTING
    } state_t;

    state_t           state_q;
    logic [23:0]      cur_addr_q;
    logic [LEN_W-1:0] remaining_q;
    logic             busy_q;
    logic             done_q;
    logic             do_read_q;
    logic [23:0]      flash_addr_q;
    logic             push_q;
    logic [7:0]       push_data_q;

    logic [FIFO_AW:0] wr_ptr_q;
    logic [FIFO_AW:0] rd_ptr_q;
    logic [7:0]       mem_q [DEPTH];

    logic             start_accept;
    logic             flush_d;
    logic             pop_d;
    logic             fifo_full;

    assign start_accept = (state_q == IDLE) && start && !abort;
    assign level        = wr_ptr_q - rd_ptr_q;
    assign fifo_full    = level[FIFO_AW];
    assign rd_valid     = |level;
    assign pop_d        = pop && rd_valid;

    // The FIFO empties on an accepted start and on every abort exit back to IDLE.
    always_comb begin
        // NOTE: default first so every path assigns flush_d and no latch is inferred.
        flush_d = 1'b0;
        unique case (state_q)
            IDLE:       flush_d = start_accept;
            ISSUE, GAP: flush_d = abort;
            WAIT_DATA:  flush_d = abort && flash.flash_data_ready;
            ABORTING:   flush_d = flash.flash_data_ready;
            default:    flush_d = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            do_read_q    <= 1'b0;
            flash_addr_q <= '0;
            push_q       <= 1'b0;
            push_data_q  <= '0;
        end else begin
            done_q      <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= flash.flash_data;
            unique case (state_q)
                IDLE: begin
                    if (start_accept) begin
                        cur_addr_q  <= start_addr;
                        remaining_q <= length;
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (flash.flash_setup_done && !fifo_full) begin
                        flash_addr_q <= cur_addr_q;
                        do_read_q    <= 1'b1;
                        state_q      <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (flash.flash_data_ready) begin
                        do_read_q <= 1'b0;
                        if (abort) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            push_q      <= 1'b1;
                            cur_addr_q  <= cur_addr_q + 24'd1;
                            remaining_q <= remaining_q - LEN_W'(1);
                            state_q     <= GAP;
                        end
                    end else if (abort) begin
                        state_q <= ABORTING;
                    end
                end
                GAP: begin
                    if (abort || remaining_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        state_q <= ISSUE;
                    end
                end
                ABORTING: begin
                    // The outstanding read must finish; its byte is dropped.
                    if (flash.flash_data_ready) begin
                        do_read_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    busy_q    <= 1'b0;
                    do_read_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_d) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_q) begin
                wr_ptr_q <= wr_ptr_q + (FIFO_AW+1)'(1);
            end
            if (pop_d) begin
                rd_ptr_q <= rd_ptr_q + (FIFO_AW+1)'(1);
            end
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_q && !flush_d) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data_q;
        end
    end

    assign rd_data = rd_valid ? mem_q[rd_ptr_q[FIFO_AW-1:0]] : 8'h00;

`ifdef FLASH_STREAM_CHECKSUM_EN
    logic [7:0] checksum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (start_accept) begin
            checksum_q <= '0;
        end else if (push_q && !flush_d) begin
            checksum_q <= checksum_q + push_data_q;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 8'h00;
`endif

    assign busy                = busy_q;
    assign done                = done_q;
    assign flash.flash_addr    = flash_addr_q;
    assign flash.flash_do_read = do_read_q;
endmodule

// File: tb/tb_flash_stream_reader.sv
// Self-checking bench for flash_stream_reader: request-level reference model plus directed and random requests.
module tb_flash_stream_reader;
    localparam int FIFO_AW = 4;
    localparam int LEN_W   = 16;
    localparam int DEPTH   = 16;
`ifdef FLASH_STREAM_CHECKSUM_EN
    localparam logic [7:0] T1_SUM = 8'h06;
`else
    localparam logic [7:0] T1_SUM = 8'h00;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [23:0]       start_addr = '0;
    logic [LEN_W-1:0]  length = '0;
    logic              abort = 1'b0;
    logic              busy;
    logic              done;
    logic              pop = 1'b0;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic [FIFO_AW:0]  level;
    logic [7:0]        checksum;

    flash_stream_reader_if fbus ();

    flash_stream_reader #(.FIFO_AW(FIFO_AW), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .flash      (fbus),
        .pop        (pop),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .level      (level),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int read_cnt = 0;
    logic [23:0] issued_q[$];
    bit prev_do_read = 1'b0;
    bit rst_seen = 1'b0;

    // Reference model: request bookkeeping and expected FIFO contents.
    bit          m_busy, m_issue, m_out, m_abort_wait, m_gap, m_done, m_pend;
    logic [23:0] m_addr, m_faddr;
    int          m_rem;
    logic [7:0]  m_pend_data, m_sum;
    logic [7:0]  m_q[$];

    bit          s_start, s_abort, s_pop, s_dr, s_setup;
    logic [23:0] s_addr;
    logic [LEN_W-1:0] s_len;
    logic [7:0]  s_data;

    int          fl_lat = 3;
    int          fl_cnt = 0;
    bit          fl_served = 1'b0;
    logic [7:0]  fl_salt = 8'h00;

    initial begin
        fbus.flash_setup_done = 1'b1;
        fbus.flash_data_ready = 1'b0;
        fbus.flash_data       = 8'h00;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_issue = 0; m_out = 0; m_abort_wait = 0; m_gap = 0;
        m_done = 0; m_pend = 0; m_addr = '0; m_faddr = '0; m_rem = 0;
        m_pend_data = '0; m_sum = '0;
        m_q.delete();
    endtask

    task automatic end_request();
        m_busy = 0; m_done = 1; m_issue = 0; m_gap = 0; m_out = 0; m_abort_wait = 0;
    endtask

    // Advance the model over one clock edge, using the inputs the DUT sampled at that edge.
    task automatic model_step();
        bit flush = 0;
        bit got = 0;
        logic [7:0] got_data = '0;
        m_done = 0;
        if (!m_busy) begin
            if (s_start && !s_abort) begin
                m_addr = s_addr;
                m_rem  = int'(s_len);
                m_sum  = '0;
                flush  = 1;
                if (s_len == 0) m_done = 1;
                else begin m_busy = 1; m_issue = 1; end
            end
        end else if (m_abort_wait) begin
            if (s_dr) begin end_request(); flush = 1; end
        end else if (m_out) begin
            if (s_dr) begin
                m_out = 0;
                if (s_abort) begin
                    end_request(); flush = 1;
                end else begin
                    got = 1; got_data = s_data;
                    m_addr = m_addr + 24'd1;
                    m_rem--;
                    m_gap = 1;
                end
            end else if (s_abort) begin
                m_abort_wait = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
            if (s_abort) begin end_request(); flush = 1; end
            else if (m_rem == 0) end_request();
            else m_issue = 1;
        end else if (m_issue) begin
            if (s_abort) begin
                end_request(); flush = 1;
            end else if (s_setup && m_q.size() < DEPTH) begin
                m_issue = 0; m_out = 1; m_faddr = m_addr;
            end
        end
        if (flush) begin
            m_q.delete();
            m_pend = 0;
        end else begin
            if (s_pop && m_q.size() > 0) void'(m_q.pop_front());
            if (m_pend) begin
                m_q.push_back(m_pend_data);
                m_sum = m_sum + m_pend_data;
                m_pend = 0;
            end
        end
        if (got) begin m_pend = 1; m_pend_data = got_data; end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            rst_seen = 1;
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
            check("rst_do_read", 32'(fbus.flash_do_read), 0);
            check("rst_flash_addr", 32'(fbus.flash_addr), 0);
            check("rst_level", 32'(level), 0);
            check("rst_rd_valid", 32'(rd_valid), 0);
            check("rst_rd_data", 32'(rd_data), 0);
            check("rst_checksum", 32'(checksum), 0);
        end else begin
            if (rst_seen) rst_seen = 0;
            else model_step();
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("do_read", 32'(fbus.flash_do_read), 32'(m_out));
            check("flash_addr", 32'(fbus.flash_addr), 32'(m_faddr));
            check("level", 32'(level), m_q.size());
            check("rd_valid", 32'(rd_valid), 32'(m_q.size() > 0));
            check("rd_data", 32'(rd_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
`ifdef FLASH_STREAM_CHECKSUM_EN
            check("checksum", 32'(checksum), 32'(m_sum));
`else
            check("checksum", 32'(checksum), 0);
`endif
            if (done) done_cnt++;
            if (fbus.flash_do_read && !prev_do_read) begin
                read_cnt++;
                issued_q.push_back(fbus.flash_addr);
            end
        end
        prev_do_read = fbus.flash_do_read;
        s_start = start; s_abort = abort; s_pop = pop; s_dr = fbus.flash_data_ready;
        s_setup = fbus.flash_setup_done; s_addr = start_addr; s_len = length; s_data = fbus.flash_data;
    end

    // One clock: clear strobes and run the flash responder just after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        pop   = 1'b0;
        if (rst) begin
            fbus.flash_data_ready = 1'b0;
            fl_cnt = 0;
            fl_served = 1'b0;
        end else if (fbus.flash_data_ready) begin
            fbus.flash_data_ready = 1'b0;
        end else if (!fbus.flash_do_read) begin
            fl_served = 1'b0;
            fl_cnt = 0;
        end else if (!fl_served) begin
            fl_cnt++;
            if (fl_cnt >= fl_lat) begin
                fbus.flash_data_ready = 1'b1;
                fbus.flash_data = fbus.flash_addr[7:0] ^ fl_salt;
                fl_served = 1'b1;
            end
        end
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            cycle();
            n++;
        end
        check(name, 32'(done_cnt != d0), 1);
    endtask

    task automatic request(input logic [23:0] a, input int len);
        start_addr = a;
        length = LEN_W'(len);
        start = 1'b1;
        cycle();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, i0, n;
        logic [23:0] t3_exp[3];
        t3_exp[0] = 24'hFFFFFE;
        t3_exp[1] = 24'hFFFFFF;
        t3_exp[2] = 24'h000000;

        repeat (3) cycle();
        rst = 1'b0;
        cycle();

        // T1: four bytes from 0x000100, three-cycle flash latency.
        fl_lat = 3; fl_salt = 8'h00;
        d0 = done_cnt;
        request(24'h000100, 4);
        wait_done(d0, 200, "t1_timeout");
        repeat (3) cycle();
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_level", 32'(level), 4);
        check("t1_checksum", 32'(checksum), 32'(T1_SUM));
        for (int i = 0; i < 4; i++) begin
            check("t1_rd_data", 32'(rd_data), i);
            pop = 1'b1;
            cycle();
        end
        check("t1_empty", 32'(rd_valid), 0);

        // T2: zero-length request.
        d0 = done_cnt; r0 = read_cnt;
        request(24'h123456, 0);
        check("t2_done", 32'(done), 1);
        check("t2_busy", 32'(busy), 0);
        cycle();
        check("t2_done_drop", 32'(done), 0);
        repeat (5) cycle();
        check("t2_no_read", read_cnt - r0, 0);
        check("t2_done_once", done_cnt - d0, 1);

        // T3: address wrap at the top of the 24-bit space.
        d0 = done_cnt; i0 = issued_q.size();
        request(24'hFFFFFE, 3);
        wait_done(d0, 200, "t3_timeout");
        check("t3_reads", issued_q.size() - i0, 3);
        for (int k = 0; k < 3; k++) begin
            if (i0 + k < issued_q.size()) check("t3_addr", 32'(issued_q[i0 + k]), 32'(t3_exp[k]));
        end

        // T4: 20 bytes, no pops until the FIFO is full.
        d0 = done_cnt; r0 = read_cnt;
        request(24'h000200, 20);
        repeat (200) cycle();
        check("t4_reads_full", read_cnt - r0, 16);
        check("t4_level_full", 32'(level), 16);
        check("t4_do_read_low", 32'(fbus.flash_do_read), 0);
        check("t4_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1;
            cycle();
        end
        wait_done(d0, 200, "t4_timeout");
        check("t4_reads_total", read_cnt - r0, 20);
        check("t4_head", 32'(rd_data), 32'h04);

        // T5: abort while a read is outstanding.
        fl_lat = 8;
        d0 = done_cnt;
        request(24'h000300, 5);
        n = 0;
        while (!fbus.flash_do_read && n < 50) begin cycle(); n++; end
        check("t5_issued", 32'(fbus.flash_do_read), 1);
        abort = 1'b1;
        cycle();
        check("t5_do_read_held", 32'(fbus.flash_do_read), 1);
        check("t5_busy_held", 32'(busy), 1);
        wait_done(d0, 50, "t5_timeout");
        check("t5_do_read_drop", 32'(fbus.flash_do_read), 0);
        check("t5_level", 32'(level), 0);
        check("t5_busy", 32'(busy), 0);
        repeat (3) cycle();
        check("t5_done_once", done_cnt - d0, 1);
        fl_lat = 2;
        d0 = done_cnt;
        request(24'h000400, 2);
        wait_done(d0, 100, "t5_restart_timeout");
        check("t5_restart_level", 32'(level), 2);
        check("t5_restart_head", 32'(rd_data), 32'h00);

        // T6: flash controller not ready for 50 cycles.
        d0 = done_cnt; r0 = read_cnt;
        fbus.flash_setup_done = 1'b0;
        request(24'h000500, 2);
        repeat (50) cycle();
        check("t6_no_read", read_cnt - r0, 0);
        check("t6_busy", 32'(busy), 1);
        fbus.flash_setup_done = 1'b1;
        wait_done(d0, 100, "t6_timeout");
        check("t6_reads", read_cnt - r0, 2);

        // T7: start and abort together in IDLE start nothing.
        d0 = done_cnt;
        start_addr = 24'h000600; length = 16'd3; start = 1'b1; abort = 1'b1;
        cycle();
        repeat (3) cycle();
        check("t7_busy", 32'(busy), 0);
        check("t7_no_done", done_cnt - d0, 0);

        // Random requests with random pops, flash latency, setup stalls and aborts.
        for (int t = 0; t < 60; t++) begin
            int pop_mod;
            fl_lat  = int'($urandom_range(1, 4));
            fl_salt = 8'($urandom);
            pop_mod = int'($urandom_range(1, 4));
            start_addr = (t % 8 == 0) ? (24'hFFFFF0 + 24'($urandom_range(0, 15))) : 24'($urandom);
            length = LEN_W'($urandom_range(0, 24));
            start = 1'b1;
            abort = ($urandom % 12 == 0);
            cycle();
            n = 0;
            while (busy && n < 1500) begin
                pop = ($urandom % pop_mod == 0);
                fbus.flash_setup_done = ($urandom % 6 != 0);
                abort = ($urandom % 60 == 0);
                start = ($urandom % 30 == 0);
                cycle();
                n++;
            end
            check("rand_idle", 32'(busy), 0);
            fbus.flash_setup_done = 1'b1;
            repeat ($urandom_range(0, 3)) begin
                pop = $urandom % 2;
                cycle();
            end
        end

        // Asynchronous reset in the middle of a request.
        fl_lat = 3;
        request(24'h000700, 10);
        repeat (12) cycle();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_do_read", 32'(fbus.flash_do_read), 0);
        check("arst_level", 32'(level), 0);
        check("arst_flash_addr", 32'(fbus.flash_addr), 0);
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        d0 = done_cnt;
        request(24'h000800, 3);
        wait_done(d0, 100, "post_rst_timeout");
        check("post_rst_level", 32'(level), 3);
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
